// File: rtl/sxp_test_ctrl.sv
// Test sequencer: streams a program into instruction memory, holds the processor
// through a settle window, runs it with one optional interrupt, and stops on finish or timeout.
//
// state  | meaning
// IDLE   | waiting for start, processor halted
// LOAD   | accepting program words, writing instruction memory
// SETTLE | halt held for SETTLE_CYC cycles after the last word
// RUN    | processor released, counting cycles and retired instructions
// DONE   | halted, results frozen until the next start
module sxp_test_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int INT_W      = 16,
  parameter int SETTLE_CYC = 3
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              halt,
  input  logic              int_rdy,
  output logic              int_req,
  output logic [INT_W-1:0]  int_num,
  input  logic              int_en,
  input  logic [CNT_W-1:0]  int_at,
  input  logic [INT_W-1:0]  int_sel,
  input  logic              inst_vld,
  input  logic              nop,
  input  logic              ext_we,
  input  logic [CNT_W-1:0]  timeout,
  output logic              done,
  output logic              timed_out,
  output logic              load_ovf,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // A zero settle length still spends one cycle in SETTLE.
  localparam int              SETTLE_LD   = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam logic [15:0]     SETTLE_INIT = 16'(SETTLE_LD);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  state_t              state_q, state_d;
  logic [15:0]         settle_q, settle_d;
  logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
  logic                idx_full_q, idx_full_d;
  logic                pend_q, pend_d;
  logic                issued_q, issued_d;

  logic                ld_ready_d, prog_we_d, halt_d, int_req_d;
  logic [ADDR_W-1:0]   prog_addr_d;
  logic [DATA_W-1:0]   prog_data_d;
  logic [INT_W-1:0]    int_num_d;
  logic                done_d, timed_out_d, load_ovf_d;
  logic [CNT_W-1:0]    inst_cnt_d, cyc_cnt_d;

  assign state = state_q;

  always_comb begin
    logic int_pend;
    int_pend    = 1'b0;
    state_d     = state_q;
    settle_d    = settle_q;
    wr_idx_d    = wr_idx_q;
    idx_full_d  = idx_full_q;
    pend_d      = pend_q;
    issued_d    = issued_q;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr;
    prog_data_d = prog_data;
    int_req_d   = 1'b0;
    int_num_d   = '0;
    timed_out_d = timed_out;
    load_ovf_d  = load_ovf;
    inst_cnt_d  = inst_cnt;
    cyc_cnt_d   = cyc_cnt;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          wr_idx_d    = '0;
          idx_full_d  = 1'b0;
          pend_d      = 1'b0;
          issued_d    = 1'b0;
          prog_addr_d = '0;
          timed_out_d = 1'b0;
          load_ovf_d  = 1'b0;
          inst_cnt_d  = '0;
          cyc_cnt_d   = '0;
        end
      end
      LOAD: begin
        if (ld_valid && ld_ready) begin
          // Once the last address is used, further words are dropped rather than wrapped.
          if (!idx_full_q) begin
            prog_we_d   = 1'b1;
            prog_addr_d = wr_idx_q;
            prog_data_d = ld_data;
            wr_idx_d    = wr_idx_q + 1'b1;
            idx_full_d  = (wr_idx_q == ADDR_MAX);
          end else begin
            load_ovf_d  = 1'b1;
          end
          if (ld_last) begin
            state_d  = SETTLE;
            settle_d = SETTLE_INIT;
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = RUN;
        else                settle_d = settle_q - 1'b1;
      end
      RUN: begin
        if (cyc_cnt != CNT_MAX) cyc_cnt_d = cyc_cnt + 1'b1;
        if (inst_vld && !nop && (inst_cnt != CNT_MAX)) inst_cnt_d = inst_cnt + 1'b1;
        // The interrupt fires on the first qualifying cycle and appears on int_req one cycle later.
        int_pend = pend_q | (int_en & (cyc_cnt == int_at) & ~issued_q);
        if (int_pend && int_rdy) begin
          int_req_d = 1'b1;
          int_num_d = int_sel;
          issued_d  = 1'b1;
          pend_d    = 1'b0;
        end else begin
          pend_d    = int_pend;
        end
        if (ext_we) begin
          state_d     = DONE;
          timed_out_d = 1'b0;
          pend_d      = 1'b0;
        end else if ((timeout != '0) && (cyc_cnt == timeout)) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
          pend_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    halt_d     = (state_d != RUN);
    ld_ready_d = (state_d == LOAD);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      wr_idx_q   <= '0;
      idx_full_q <= 1'b0;
      pend_q     <= 1'b0;
      issued_q   <= 1'b0;
      ld_ready   <= 1'b0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      halt       <= 1'b1;
      int_req    <= 1'b0;
      int_num    <= '0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
      load_ovf   <= 1'b0;
      inst_cnt   <= '0;
      cyc_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      wr_idx_q   <= wr_idx_d;
      idx_full_q <= idx_full_d;
      pend_q     <= pend_d;
      issued_q   <= issued_d;
      ld_ready   <= ld_ready_d;
      prog_we    <= prog_we_d;
      prog_addr  <= prog_addr_d;
      prog_data  <= prog_data_d;
      halt       <= halt_d;
      int_req    <= int_req_d;
      int_num    <= int_num_d;
      done       <= done_d;
      timed_out  <= timed_out_d;
      load_ovf   <= load_ovf_d;
      inst_cnt   <= inst_cnt_d;
      cyc_cnt    <= cyc_cnt_d;
    end
  end

endmodule

// File: tb/tb_sxp_test_ctrl.sv
// Directed bench for sxp_test_ctrl: a default instance plus a 2-bit-address instance
// sharing the same stimulus, the latter used for the load-overflow case.
module tb_sxp_test_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int INT_W  = 16;

  logic clk = 1'b0;
  logic reset_b = 1'b0, start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic int_rdy = 1'b0, int_en = 1'b0, inst_vld = 1'b0, nop = 1'b0, ext_we = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [CNT_W-1:0]  int_at = '0, timeout = '0;
  logic [INT_W-1:0]  int_sel = '0;

  logic              ld_ready, prog_we, halt, int_req, done, timed_out, load_ovf;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [INT_W-1:0]  int_num;
  logic [CNT_W-1:0]  inst_cnt, cyc_cnt;
  logic [2:0]        state;

  logic              b_ld_ready, b_prog_we, b_halt, b_int_req, b_done, b_timed_out, b_load_ovf;
  logic [1:0]        b_prog_addr;
  logic [DATA_W-1:0] b_prog_data;
  logic [INT_W-1:0]  b_int_num;
  logic [CNT_W-1:0]  b_inst_cnt, b_cyc_cnt;
  logic [2:0]        b_state;

  int checks = 0;
  int errors = 0;
  int pulses, pulse_cyc, pulse_num;

  always #5 clk = ~clk;

  sxp_test_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .INT_W(INT_W), .SETTLE_CYC(3)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .halt(halt), .int_rdy(int_rdy), .int_req(int_req), .int_num(int_num),
    .int_en(int_en), .int_at(int_at), .int_sel(int_sel), .inst_vld(inst_vld), .nop(nop),
    .ext_we(ext_we), .timeout(timeout), .done(done), .timed_out(timed_out), .load_ovf(load_ovf),
    .inst_cnt(inst_cnt), .cyc_cnt(cyc_cnt), .state(state));

  sxp_test_ctrl #(.ADDR_W(2), .DATA_W(DATA_W), .CNT_W(CNT_W), .INT_W(INT_W), .SETTLE_CYC(3)) dut2 (
    .clk(clk), .reset_b(reset_b), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(b_ld_ready), .prog_we(b_prog_we), .prog_addr(b_prog_addr),
    .prog_data(b_prog_data), .halt(b_halt), .int_rdy(int_rdy), .int_req(b_int_req), .int_num(b_int_num),
    .int_en(int_en), .int_at(int_at), .int_sel(int_sel), .inst_vld(inst_vld), .nop(nop),
    .ext_we(ext_we), .timeout(timeout), .done(b_done), .timed_out(b_timed_out), .load_ovf(b_load_ovf),
    .inst_cnt(b_inst_cnt), .cyc_cnt(b_cyc_cnt), .state(b_state));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_state", state, 64'd1);
    chk("start_ld_ready", ld_ready, 64'd1);
    chk("start_done_clr", done, 64'd0);
    chk("start_cyc_clr", cyc_cnt, 64'd0);
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + 32'(i);
      ld_last  = (i == n - 1);
      step();
      chk("load_we", prog_we, 64'd1);
      chk("load_addr", prog_addr, 64'(i));
      chk("load_data", prog_data, 64'(base + 32'(i)));
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic settle_chk();
    for (int i = 0; i < 3; i++) begin
      chk("settle_state", state, 64'd2);
      chk("settle_halt", halt, 64'd1);
      chk("settle_ld_ready", ld_ready, 64'd0);
      step();
    end
    chk("run_state", state, 64'd3);
    chk("run_halt", halt, 64'd0);
    chk("run_cyc0", cyc_cnt, 64'd0);
  endtask

  // Drives the run-time inputs from the observed cycle count; 10 retires, nops at cycles 2,5,8.
  task automatic run_phase(input int max_cyc, input bit ext_en, input int ext_at, input int rdy_from,
                           output int np, output int pc, output int pn);
    int c;
    np = 0; pc = -1; pn = -1;
    for (int k = 0; k < max_cyc && state == 3'd3; k++) begin
      c        = int'(cyc_cnt);
      inst_vld = (c < 10);
      nop      = (c == 2) || (c == 5) || (c == 8);
      int_rdy  = (c >= rdy_from);
      ext_we   = ext_en && (c == ext_at);
      step();
      if (int_req) begin
        np++;
        pc = int'(cyc_cnt);
        pn = int'(int_num);
      end
    end
    inst_vld = 1'b0; nop = 1'b0; ext_we = 1'b0; int_rdy = 1'b0;
    chk("run_ends_done", state, 64'd4);
  endtask

  initial begin
    // Reset
    step();
    step();
    chk("rst_state", state, 64'd0);
    chk("rst_halt", halt, 64'd1);
    chk("rst_ld_ready", ld_ready, 64'd0);
    chk("rst_prog_we", prog_we, 64'd0);
    chk("rst_int_req", int_req, 64'd0);
    chk("rst_done", done, 64'd0);
    reset_b = 1'b1;
    step();
    chk("idle_state", state, 64'd0);

    // Run 1: four words, interrupt at 13 with int_rdy high, finish at cycle 30
    int_en = 1'b1; int_at = 32'd13; int_sel = 16'd1; timeout = '0;
    do_start();
    load_words(4, 32'hA0);
    settle_chk();
    run_phase(200, 1'b1, 30, 0, pulses, pulse_cyc, pulse_num);
    chk("r1_pulses", 64'(pulses), 64'd1);
    chk("r1_pulse_cyc", 64'(pulse_cyc), 64'd14);
    chk("r1_pulse_num", 64'(pulse_num), 64'd1);
    chk("r1_done", done, 64'd1);
    chk("r1_timed_out", timed_out, 64'd0);
    chk("r1_halt", halt, 64'd1);
    chk("r1_inst_cnt", inst_cnt, 64'd7);
    chk("r1_cyc_cnt", cyc_cnt, 64'd31);
    chk("r1_int_num_idle", int_num, 64'd0);
    inst_vld = 1'b1;
    step(); step(); step();
    inst_vld = 1'b0;
    chk("r1_frozen_cyc", cyc_cnt, 64'd31);
    chk("r1_frozen_inst", inst_cnt, 64'd7);
    chk("r1_frozen_state", state, 64'd4);

    // Run 2: int_rdy withheld until cycle 20, timeout at 50
    int_sel = 16'h2A5; timeout = 32'd50;
    do_start();
    chk("r2_inst_clr", inst_cnt, 64'd0);
    load_words(2, 32'hC0);
    settle_chk();
    run_phase(200, 1'b0, 0, 20, pulses, pulse_cyc, pulse_num);
    chk("r2_pulses", 64'(pulses), 64'd1);
    chk("r2_pulse_cyc", 64'(pulse_cyc), 64'd21);
    chk("r2_pulse_num", 64'(pulse_num), 64'h2A5);
    chk("r2_timed_out", timed_out, 64'd1);
    chk("r2_done", done, 64'd1);
    chk("r2_cyc_cnt", cyc_cnt, 64'd51);
    chk("r2_inst_cnt", inst_cnt, 64'd7);

    // Run 3: ext_we on the same cycle as timeout, no interrupt
    int_en = 1'b0;
    do_start();
    chk("r3_timed_out_clr", timed_out, 64'd0);
    load_words(1, 32'hD0);
    settle_chk();
    run_phase(200, 1'b1, 50, 0, pulses, pulse_cyc, pulse_num);
    chk("r3_pulses", 64'(pulses), 64'd0);
    chk("r3_timed_out", timed_out, 64'd0);
    chk("r3_cyc_cnt", cyc_cnt, 64'd51);

    // Overflow on the 4-deep instance, then reset mid-run with an interrupt about to fire
    timeout = '0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hB0 + 32'(i);
      ld_last  = (i == 4);
      step();
      if (i < 4) begin
        chk("ovf_we", b_prog_we, 64'd1);
        chk("ovf_addr", b_prog_addr, 64'(i));
        chk("ovf_flag_low", b_load_ovf, 64'd0);
      end else begin
        chk("ovf_we_suppressed", b_prog_we, 64'd0);
        chk("ovf_flag", b_load_ovf, 64'd1);
        chk("ovf_wide_addr", prog_addr, 64'd4);
        chk("ovf_wide_flag", load_ovf, 64'd0);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    step(); step(); step();
    chk("ovf_run_state", b_state, 64'd3);
    chk("ovf_sticky", b_load_ovf, 64'd1);
    int_en = 1'b1; int_at = 32'd1; int_rdy = 1'b1;
    step();
    chk("pre_rst_cyc", b_cyc_cnt, 64'd1);
    reset_b = 1'b0; ld_valid = 1'b1;
    step();
    chk("rst_run_state", b_state, 64'd0);
    chk("rst_run_halt", b_halt, 64'd1);
    chk("rst_run_int_req", b_int_req, 64'd0);
    chk("rst_run_cyc", b_cyc_cnt, 64'd0);
    chk("rst_run_ovf", b_load_ovf, 64'd0);
    reset_b = 1'b1;
    step();
    chk("post_rst_int_req", int_req, 64'd0);
    chk("post_rst_prog_we", prog_we, 64'd0);
    chk("post_rst_ld_ready", ld_ready, 64'd0);
    chk("post_rst_state", state, 64'd0);
    ld_valid = 1'b0; int_en = 1'b0; int_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
